fb_fader: RTL and testbench
===========================

Name: fb_fader

Overview:
- AXI master that sweeps the whole framebuffer once per N frames.
- For each pixel it reads the word, then either decays the meta intensity field by a step (FADE) or clears it (BLANK), and writes the result back.
- Sits on the third (in2) port of the 3-to-2 SRAM arbiter, beside the fb writer and the VGA pixel-stream reader.
- Provides the blanking/fade-behind-the-beam function for vector-display emulation.

Parameters:
- PIXEL_BITS, 12, color bits per pixel (3 equal channels).
- META_BITS, 4, intensity field width; must be >= 1.
- H_VISIBLE, 640, framebuffer width in pixels.
- V_VISIBLE, 480, framebuffer height in pixels.
- AXI_ADDR_WIDTH, 20, word address width.
- AXI_DATA_WIDTH, 16, word width; must be >= PIXEL_BITS+META_BITS.
- FRAMES_PER_PASS, 1, number of vsync assertions per sweep start; must be >= 1.
- VSYNC_ACTIVE_LOW, 1, polarity of the vsync input.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  allow sweeps to start; deassertion aborts at the next pixel boundary.
- vsync  in  1  frame sync from the pixel stream (gfx_vsync).
- mode  in  1  0 = FADE, 1 = BLANK; sampled at pass start.
- fade_step  in  META_BITS  decrement applied to meta; sampled at pass start.
- busy  out  1  high while a pass is in progress.
- overrun  out  1  sticky; a pass start was due while busy. Cleared only by reset.
- sram_axi_araddr / arvalid / arready  out/out/in  AXI_ADDR_WIDTH/1/1  read address channel.
- sram_axi_rdata / rresp / rvalid / rready  in/in/in/out  AXI_DATA_WIDTH/2/1/1  read data channel.
- sram_axi_awaddr / awvalid / awready  out/out/in  AXI_ADDR_WIDTH/1/1  write address channel.
- sram_axi_wdata / wstrb / wvalid / wready  out/out/out/in  AXI_DATA_WIDTH/(AXI_DATA_WIDTH+7)/8/1/1  write data channel.
- sram_axi_bresp / bvalid / bready  in/in/out  2/1/1  write response channel.

Behaviour:
- Reset values: busy=0, overrun=0, all *valid=0, rready=0, bready=0, addresses=0, wdata=0, wstrb=all ones (constant), frame counter=0, FSM=IDLE.
- Vsync edge: assertion edge detected with a registered previous value. On each edge the frame counter increments; it wraps to 0 at FRAMES_PER_PASS-1, and the wrap is a "pass due" event.
- Pass due:
  - In IDLE with enable=1: latch mode and fade_step, set addr=0, set busy=1 on the next cycle, go to RD_ADDR.
  - While busy: set overrun=1, no restart, current pass continues.
  - With enable=0: ignored.
- RD_ADDR: arvalid=1, araddr=addr. On arvalid&&arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid, compute the new word:
  - Word layout: bits [PIXEL_BITS+META_BITS-1:META_BITS] = color, [META_BITS-1:0] = meta; bits above are preserved unchanged.
  - FADE: meta' = (meta > step) ? meta - step : 0. Saturating, no wrap. If meta'==0, color'=0.
  - BLANK: color'=0, meta'=0.
  - If new word == read word, skip the write and go to NEXT. Otherwise go to WRITE.
- WRITE: awvalid=wvalid=1 together, awaddr=addr. Each valid drops independently on its own handshake; both channels must complete before going to WR_RESP.
- WR_RESP: bready=1. On bvalid go to NEXT. bresp and rresp are ignored.
- NEXT:
  - If addr == H_VISIBLE*V_VISIBLE-1, or enable==0: go to IDLE, busy=0.
  - Otherwise addr+1, go to RD_ADDR.
- Only one transaction is outstanding at a time. Minimum per pixel with zero-wait slave: 6 cycles with write, 3 cycles skipped.
- Reset mid-operation: all valids drop on the reset edge and the FSM goes to IDLE. The in-flight beat is abandoned; the slave shares the same reset.
- A pass-due event that coincides with the last pixel's NEXT counts as overrun (busy is still 1).

Decomposition:
- Shared package gfx_pkg:
  - fader_mode_t enum (FADE_MODE, BLANK_MODE).
  - fader_state_t enum (IDLE, RD_ADDR, RD_DATA, WRITE, WR_RESP, NEXT).
- Sub-module fb_fade_pixel: purely combinational {word, mode, step} -> {new_word, changed}. Keeps the arithmetic unit-testable.

Test Plan:
- H=4, V=2, FADE, step=3, all words meta=5, color=0xFFF, zero-wait slave, one vsync edge -> 8 reads and 8 writes, addrs 0..7, each written word color=0xFFF meta=2; busy falls after addr 7.
- Same setup with meta=2, step=3 -> every written word is 0x0000 (saturate, color cleared).
- Memory preloaded all zero, FADE -> 8 reads, 0 writes (skip), pass length 24 cycles.
- FRAMES_PER_PASS=3, 7 vsync edges -> passes start only on edges 3 and 6.
- Vsync edge while busy -> overrun=1 and stays 1 after the pass ends; no second pass starts.
- Slave with random arready/awready/wready/rvalid/bvalid stalls, BLANK mode -> memory all zero at the end. Reset asserted mid-WRITE -> next cycle all valids 0, busy 0.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared types for the framebuffer fader: pass mode, FSM states and a
// small helper for sizing the frame counter.
package gfx_pkg;

  typedef enum logic {
    FADE_MODE  = 1'b0,
    BLANK_MODE = 1'b1
  } fader_mode_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WRITE   = 3'd3,
    WR_RESP = 3'd4,
    NEXT    = 3'd5
  } fader_state_t;

  // Frame counter width; at least one bit even when every frame starts a pass.
  function automatic int unsigned fcnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fb_fade_pixel.sv
// Per-word fade/blank arithmetic. Purely combinational so the pixel rule
// can be exercised on its own, away from the bus sequencing.
module fb_fade_pixel
  import gfx_pkg::*;
#(
  parameter int unsigned PIXEL_BITS = 12,
  parameter int unsigned META_BITS  = 4,
  parameter int unsigned DATA_W     = 16
) (
  input  logic [DATA_W-1:0]    word,
  input  fader_mode_t          mode,
  input  logic [META_BITS-1:0] step,
  output logic [DATA_W-1:0]    new_word,
  output logic                 changed
);

  logic [META_BITS-1:0]  meta;
  logic [META_BITS-1:0]  meta_new;
  logic [PIXEL_BITS-1:0] color;
  logic [PIXEL_BITS-1:0] color_new;

  assign meta  = word[META_BITS-1:0];
  assign color = word[PIXEL_BITS+META_BITS-1:META_BITS];

  // Saturating decay; a pixel whose intensity reaches zero loses its colour.
  // Bits above the colour field pass through untouched.
  always_comb begin
    meta_new  = '0;
    color_new = '0;
    if (mode == FADE_MODE) begin
      meta_new  = (meta > step) ? meta - step : '0;
      color_new = (meta_new == '0) ? '0 : color;
    end
    new_word = word;
    new_word[META_BITS-1:0]                    = meta_new;
    new_word[PIXEL_BITS+META_BITS-1:META_BITS] = color_new;
  end

  assign changed = (new_word != word);

endmodule

// File: rtl/fb_fader.sv
// Framebuffer fader: once every FRAMES_PER_PASS vsyncs, walks every pixel
// word with a read-modify-write over AXI, decaying or clearing its
// intensity. One transaction in flight at a time.
module fb_fader
  import gfx_pkg::*;
#(
  parameter int unsigned PIXEL_BITS       = 12,
  parameter int unsigned META_BITS        = 4,
  parameter int unsigned H_VISIBLE        = 640,
  parameter int unsigned V_VISIBLE        = 480,
  parameter int unsigned AXI_ADDR_WIDTH   = 20,
  parameter int unsigned AXI_DATA_WIDTH   = 16,
  parameter int unsigned FRAMES_PER_PASS  = 1,
  parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            vsync,
  input  logic                            mode,
  input  logic [META_BITS-1:0]            fade_step,
  output logic                            busy,
  output logic                            overrun,
  output logic [AXI_ADDR_WIDTH-1:0]       sram_axi_araddr,
  output logic                            sram_axi_arvalid,
  input  logic                            sram_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]       sram_axi_rdata,
  input  logic [1:0]                      sram_axi_rresp,
  input  logic                            sram_axi_rvalid,
  output logic                            sram_axi_rready,
  output logic [AXI_ADDR_WIDTH-1:0]       sram_axi_awaddr,
  output logic                            sram_axi_awvalid,
  input  logic                            sram_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]       sram_axi_wdata,
  output logic [(AXI_DATA_WIDTH+7)/8-1:0] sram_axi_wstrb,
  output logic                            sram_axi_wvalid,
  input  logic                            sram_axi_wready,
  input  logic [1:0]                      sram_axi_bresp,
  input  logic                            sram_axi_bvalid,
  output logic                            sram_axi_bready
);

  localparam int unsigned FCW = fcnt_width(FRAMES_PER_PASS);
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(FRAMES_PER_PASS - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] LAST_ADDR =
    AXI_ADDR_WIDTH'(H_VISIBLE * V_VISIBLE - 1);

  fader_state_t                state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  fader_mode_t                 mode_q, mode_d;
  logic [META_BITS-1:0]        step_q, step_d;
  logic                        busy_q, busy_d;
  logic                        overrun_q, overrun_d;
  logic                        vs_prev_q, vs_prev_d;
  logic [FCW-1:0]              fcnt_q, fcnt_d;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                        aw_done_q, aw_done_d;
  logic                        w_done_q, w_done_d;

  logic                        vs_act;
  logic                        vs_edge;
  logic                        pass_due;
  logic [AXI_DATA_WIDTH-1:0]   px_new;
  logic                        px_changed;
  logic                        unused_resp;

  // Responses carry no information this block acts on.
  assign unused_resp = ^{sram_axi_rresp, sram_axi_bresp};

  assign vs_act   = VSYNC_ACTIVE_LOW ? ~vsync : vsync;
  assign vs_edge  = vs_act & ~vs_prev_q;
  assign pass_due = vs_edge && (fcnt_q == FCNT_LAST);

  fb_fade_pixel #(
    .PIXEL_BITS (PIXEL_BITS),
    .META_BITS  (META_BITS),
    .DATA_W     (AXI_DATA_WIDTH)
  ) u_pixel (
    .word     (sram_axi_rdata),
    .mode     (mode_q),
    .step     (step_q),
    .new_word (px_new),
    .changed  (px_changed)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      mode_q    <= FADE_MODE;
      step_q    <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      vs_prev_q <= 1'b0;
      fcnt_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      mode_q    <= mode_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      vs_prev_q <= vs_prev_d;
      fcnt_q    <= fcnt_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state: one pixel's read, optional write, then advance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pass_due && enable) state_d = RD_ADDR;
      RD_ADDR: if (sram_axi_arready) state_d = RD_DATA;
      RD_DATA: if (sram_axi_rvalid) state_d = px_changed ? WRITE : NEXT;
      // Leave only once both address and data beats are registered as done.
      WRITE:   if (aw_done_q && w_done_q) state_d = WR_RESP;
      WR_RESP: if (sram_axi_bvalid) state_d = NEXT;
      NEXT:    state_d = (addr_q == LAST_ADDR || !enable) ? IDLE : RD_ADDR;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates: frame counting, pass latch, word capture, handshakes.
  always_comb begin
    vs_prev_d = vs_act;
    fcnt_d    = fcnt_q;
    addr_d    = addr_q;
    mode_d    = mode_q;
    step_d    = step_q;
    busy_d    = busy_q;
    overrun_d = overrun_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    if (vs_edge) fcnt_d = pass_due ? '0 : fcnt_q + 1'b1;

    // A disabled fader ignores pass starts entirely, busy or not.
    if (pass_due && enable) begin
      if (busy_q) begin
        overrun_d = 1'b1;
      end else if (state_q == IDLE) begin
        addr_d = '0;
        mode_d = fader_mode_t'(mode);
        step_d = fade_step;
        busy_d = 1'b1;
      end
    end

    case (state_q)
      RD_DATA: if (sram_axi_rvalid) wdata_d = px_new;
      WRITE: begin
        if (aw_done_q && w_done_q) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          if (sram_axi_awready) aw_done_d = 1'b1;
          if (sram_axi_wready)  w_done_d  = 1'b1;
        end
      end
      NEXT: begin
        if (addr_q == LAST_ADDR || !enable) busy_d = 1'b0;
        else addr_d = addr_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Bus outputs decoded from state; addresses and write data are registers.
  always_comb begin
    sram_axi_arvalid = (state_q == RD_ADDR);
    sram_axi_rready  = (state_q == RD_DATA);
    sram_axi_awvalid = (state_q == WRITE) && !aw_done_q;
    sram_axi_wvalid  = (state_q == WRITE) && !w_done_q;
    sram_axi_bready  = (state_q == WR_RESP);
    sram_axi_araddr  = addr_q;
    sram_axi_awaddr  = addr_q;
    sram_axi_wdata   = wdata_q;
    sram_axi_wstrb   = '1;
    busy             = busy_q;
    overrun          = overrun_q;
  end

endmodule

// File: tb/tb_fb_fader.sv
// Bench for fb_fader: pixel-rule vector table plus directed passes against
// a small AXI SRAM model with optional random stalls.
module tb_fb_fader;
  import gfx_pkg::*;

  localparam int P = 12, M = 4, D = 16, AW = 20, SW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, vsync = 1'b1, vsync_b = 1'b1, mode = 1'b0;
  logic [M-1:0] fade_step = '0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- DUT A: 4x2 framebuffer, pass every vsync
  logic busy, overrun, arvalid, arready, rvalid, rready, awvalid, awready;
  logic wvalid, wready, bvalid, bready;
  logic [AW-1:0] araddr, awaddr;
  logic [D-1:0] rdata, wdata;
  logic [SW-1:0] wstrb;

  fb_fader #(.PIXEL_BITS(P), .META_BITS(M), .H_VISIBLE(4), .V_VISIBLE(2),
             .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(D), .FRAMES_PER_PASS(1),
             .VSYNC_ACTIVE_LOW(1'b1)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .vsync(vsync), .mode(mode),
    .fade_step(fade_step), .busy(busy), .overrun(overrun),
    .sram_axi_araddr(araddr), .sram_axi_arvalid(arvalid), .sram_axi_arready(arready),
    .sram_axi_rdata(rdata), .sram_axi_rresp(2'b00), .sram_axi_rvalid(rvalid),
    .sram_axi_rready(rready), .sram_axi_awaddr(awaddr), .sram_axi_awvalid(awvalid),
    .sram_axi_awready(awready), .sram_axi_wdata(wdata), .sram_axi_wstrb(wstrb),
    .sram_axi_wvalid(wvalid), .sram_axi_wready(wready), .sram_axi_bresp(2'b00),
    .sram_axi_bvalid(bvalid), .sram_axi_bready(bready));

  // SRAM model for DUT A
  logic [D-1:0] mem [8];
  logic [D-1:0] load_img [8];
  logic load = 1'b0, rnd = 1'b0;
  logic rpend, bpend, got_aw, got_w;
  logic [AW-1:0] aw_a;
  logic [D-1:0] w_d;
  int rd_cnt, wr_cnt;
  logic [AW-1:0] rd_alog [64];
  logic [AW-1:0] wr_alog [64];
  logic [D-1:0]  wr_dlog [64];
  logic aw_hs, w_hs, aw_now, w_now;
  logic [AW-1:0] wa;
  logic [D-1:0] wd;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign aw_now = got_aw || aw_hs;
  assign w_now  = got_w || w_hs;
  assign wa     = aw_hs ? awaddr : aw_a;
  assign wd     = w_hs ? wdata : w_d;

  always @(posedge clk) begin
    if (load) for (int i = 0; i < 8; i++) mem[i] <= load_img[i];
    if (reset) begin
      arready <= 1'b0; awready <= 1'b0; wready <= 1'b0;
      rvalid <= 1'b0; rpend <= 1'b0; bvalid <= 1'b0; bpend <= 1'b0;
      got_aw <= 1'b0; got_w <= 1'b0; rdata <= '0; aw_a <= '0; w_d <= '0;
      rd_cnt <= 0; wr_cnt <= 0;
    end else begin
      arready <= rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      awready <= rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      wready  <= rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (arvalid && arready) begin
        rdata <= mem[araddr[2:0]];
        if (rd_cnt < 64) rd_alog[rd_cnt] <= araddr;
        rd_cnt <= rd_cnt + 1;
        if (!rnd || $urandom_range(0, 1) == 1) rvalid <= 1'b1; else rpend <= 1'b1;
      end else if (rpend && $urandom_range(0, 1) == 1) begin
        rvalid <= 1'b1; rpend <= 1'b0;
      end
      if (rvalid && rready) rvalid <= 1'b0;
      if (aw_hs) aw_a <= awaddr;
      if (w_hs) w_d <= wdata;
      if (aw_now && w_now) begin
        mem[wa[2:0]] <= wd;
        if (wr_cnt < 64) begin wr_alog[wr_cnt] <= wa; wr_dlog[wr_cnt] <= wd; end
        wr_cnt <= wr_cnt + 1;
        got_aw <= 1'b0; got_w <= 1'b0;
        if (!rnd || $urandom_range(0, 1) == 1) bvalid <= 1'b1; else bpend <= 1'b1;
      end else begin
        got_aw <= aw_now; got_w <= w_now;
        if (bpend && $urandom_range(0, 1) == 1) begin bvalid <= 1'b1; bpend <= 1'b0; end
      end
      if (bvalid && bready) bvalid <= 1'b0;
    end
  end

  // ---------------- DUT B: pass every third vsync, always-ready zero memory
  logic busy_b, overrun_b, arvalid_b, rready_b, awvalid_b, wvalid_b, bready_b;
  logic [AW-1:0] araddr_b, awaddr_b;
  logic [D-1:0] wdata_b;
  logic [SW-1:0] wstrb_b;
  logic busy_b_prev;
  int starts_b;

  fb_fader #(.PIXEL_BITS(P), .META_BITS(M), .H_VISIBLE(4), .V_VISIBLE(2),
             .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(D), .FRAMES_PER_PASS(3),
             .VSYNC_ACTIVE_LOW(1'b1)) u_dut_b (
    .clk(clk), .reset(reset), .enable(1'b1), .vsync(vsync_b), .mode(1'b0),
    .fade_step(4'd1), .busy(busy_b), .overrun(overrun_b),
    .sram_axi_araddr(araddr_b), .sram_axi_arvalid(arvalid_b), .sram_axi_arready(1'b1),
    .sram_axi_rdata(16'h0000), .sram_axi_rresp(2'b00), .sram_axi_rvalid(1'b1),
    .sram_axi_rready(rready_b), .sram_axi_awaddr(awaddr_b), .sram_axi_awvalid(awvalid_b),
    .sram_axi_awready(1'b1), .sram_axi_wdata(wdata_b), .sram_axi_wstrb(wstrb_b),
    .sram_axi_wvalid(wvalid_b), .sram_axi_wready(1'b1), .sram_axi_bresp(2'b00),
    .sram_axi_bvalid(1'b1), .sram_axi_bready(bready_b));

  always @(posedge clk) begin
    if (reset) begin busy_b_prev <= 1'b0; starts_b <= 0; end
    else begin
      busy_b_prev <= busy_b;
      if (busy_b && !busy_b_prev) starts_b <= starts_b + 1;
    end
  end

  // ---------------- standalone pixel unit for the vector table
  logic [D-1:0] px_w, px_nw;
  fader_mode_t px_m;
  logic [M-1:0] px_s;
  logic px_ch;
  fb_fade_pixel #(.PIXEL_BITS(P), .META_BITS(M), .DATA_W(D)) u_px (
    .word(px_w), .mode(px_m), .step(px_s), .new_word(px_nw), .changed(px_ch));

  typedef struct {
    logic [D-1:0] w;
    logic         m;
    logic [M-1:0] s;
    logic [D-1:0] nw;
    logic         ch;
  } pvec_t;
  pvec_t tbl [11];

  // ---------------- helpers
  task automatic load_all(input logic [D-1:0] v);
    for (int i = 0; i < 8; i++) load_img[i] = v;
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic pulse_a();
    @(negedge clk) vsync = 1'b0;
    @(negedge clk) vsync = 1'b1;
  endtask

  // Waits for busy to drop, counting busy cycles; expired bound is a failure.
  task automatic wait_idle(input string name, input int limit, output int cyc);
    cyc = 0;
    while (busy && cyc < limit) begin cyc++; @(negedge clk); end
    if (busy) check({name, "_timeout"}, 32'(busy), 32'd0);
  endtask

  int cyc, rb, wb, nz, k;

  initial begin
    tbl[0]  = '{16'hFFF5, 1'b0, 4'd3,  16'hFFF2, 1'b1};
    tbl[1]  = '{16'hFFF2, 1'b0, 4'd3,  16'h0000, 1'b1};
    tbl[2]  = '{16'hABC3, 1'b0, 4'd3,  16'h0000, 1'b1};
    tbl[3]  = '{16'hABC4, 1'b0, 4'd3,  16'hABC1, 1'b1};
    tbl[4]  = '{16'h0000, 1'b0, 4'd3,  16'h0000, 1'b0};
    tbl[5]  = '{16'h1235, 1'b0, 4'd0,  16'h1235, 1'b0};
    tbl[6]  = '{16'h1230, 1'b0, 4'd0,  16'h0000, 1'b1};
    tbl[7]  = '{16'hABCD, 1'b1, 4'd2,  16'h0000, 1'b1};
    tbl[8]  = '{16'h0000, 1'b1, 4'd2,  16'h0000, 1'b0};
    tbl[9]  = '{16'h000F, 1'b0, 4'd15, 16'h0000, 1'b1};
    tbl[10] = '{16'h800F, 1'b0, 4'd1,  16'h800E, 1'b1};

    for (int i = 0; i < 11; i++) begin
      px_w = tbl[i].w; px_m = fader_mode_t'(tbl[i].m); px_s = tbl[i].s;
      #1;
      check($sformatf("px%0d_word", i), 32'(px_nw), 32'(tbl[i].nw));
      check($sformatf("px%0d_changed", i), 32'(px_ch), 32'(tbl[i].ch));
    end

    // reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
    check("rst_addr_data", {araddr, awaddr, wdata} == '0, 1);
    check("rst_wstrb", 32'(wstrb), 32'h3);
    check("rst_b_busy", 32'(busy_b), 0);

    // frame divider: starts only on the 3rd and 6th edge
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk) vsync_b = 1'b0;
      @(negedge clk) vsync_b = 1'b1;
      repeat (40) @(negedge clk);
      k = (e >= 6) ? 2 : (e >= 3) ? 1 : 0;
      check($sformatf("fpp_starts_after_edge%0d", e), 32'(starts_b), 32'(k));
    end
    check("fpp_no_overrun", 32'(overrun_b), 0);

    // disabled: pass start ignored
    load_all(16'hFFF5);
    enable = 1'b0;
    pulse_a();
    repeat (10) @(negedge clk);
    check("dis_busy", 32'(busy), 0);
    check("dis_no_reads", 32'(rd_cnt), 0);

    // FADE meta 5 step 3; inputs changed after start must not matter
    enable = 1'b1; mode = 1'b0; fade_step = 4'd3;
    rb = rd_cnt; wb = wr_cnt;
    pulse_a();
    mode = 1'b1; fade_step = 4'd0;
    wait_idle("fade5", 2000, cyc);
    check("fade5_reads", 32'(rd_cnt - rb), 8);
    check("fade5_writes", 32'(wr_cnt - wb), 8);
    check("fade5_cycles", 32'(cyc), 48);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fade5_raddr%0d", i), 32'(rd_alog[rb+i]), 32'(i));
      check($sformatf("fade5_waddr%0d", i), 32'(wr_alog[wb+i]), 32'(i));
      check($sformatf("fade5_wdata%0d", i), 32'(wr_dlog[wb+i]), 32'hFFF2);
    end

    // FADE meta 2 step 3: saturates to zero and clears colour
    mode = 1'b0; fade_step = 4'd3;
    load_all(16'hFFF2);
    wb = wr_cnt;
    pulse_a();
    wait_idle("fade2", 2000, cyc);
    check("fade2_writes", 32'(wr_cnt - wb), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("fade2_wdata%0d", i), 32'(wr_dlog[wb+i]), 32'h0000);

    // all zero: nothing changes, every write skipped
    load_all(16'h0000);
    rb = rd_cnt; wb = wr_cnt;
    pulse_a();
    wait_idle("zero", 2000, cyc);
    check("zero_reads", 32'(rd_cnt - rb), 8);
    check("zero_writes", 32'(wr_cnt - wb), 0);
    check("zero_cycles", 32'(cyc), 24);

    // BLANK with random slave stalls
    nz = 0;
    for (int i = 0; i < 8; i++) begin
      load_img[i] = (i % 3 == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
      if (load_img[i] != 0) nz++;
    end
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
    rnd = 1'b1; mode = 1'b1;
    wb = wr_cnt;
    pulse_a();
    wait_idle("blank", 5000, cyc);
    check("blank_writes", 32'(wr_cnt - wb), 32'(nz));
    for (int i = 0; i < 8; i++)
      check($sformatf("blank_mem%0d", i), 32'(mem[i]), 0);
    rnd = 1'b0; mode = 1'b0;

    // enable dropped mid-pass aborts at the next pixel boundary
    load_all(16'hFFF5);
    rb = rd_cnt;
    pulse_a();
    repeat (8) @(negedge clk);
    enable = 1'b0;
    wait_idle("abort", 20, cyc);
    check("abort_busy", 32'(busy), 0);
    check("abort_partial", 32'((rd_cnt - rb) < 8), 1);
    enable = 1'b1;

    // pass start while busy: sticky overrun, no second pass
    load_all(16'hFFF5);
    wb = wr_cnt;
    pulse_a();
    repeat (5) @(negedge clk);
    check("ovr_before", 32'(overrun), 0);
    pulse_a();
    check("ovr_set", 32'(overrun), 1);
    wait_idle("ovr", 2000, cyc);
    repeat (60) @(negedge clk);
    check("ovr_sticky", 32'(overrun), 1);
    check("ovr_no_restart", 32'(busy), 0);
    check("ovr_one_pass", 32'(wr_cnt - wb), 8);

    // reset while in WRITE
    load_all(16'hFFF5);
    pulse_a();
    k = 0;
    while (!awvalid && k < 50) begin k++; @(negedge clk); end
    check("rstw_reached_write", 32'(awvalid), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstw_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
    check("rstw_busy", 32'(busy), 0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check("rstw_overrun_clr", 32'(overrun), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
